// File: rtl/mem_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mem_stage : pipeline MEM stage; load alignment, read-data hold, fwd.   |
// | Revision  : 1.0                                                        |
// +------------------------------------------------------------------------+
module mem_stage (
  input  logic         clk,
  input  logic         reset,
  output logic         mem_allowin,
  input  logic         ex_mem_valid,
  input  logic [189:0] ex_mem_bus,
  input  logic [31:0]  data_sram_rdata,
  output logic         mem_wb_valid,
  input  logic         wb_allowin,
  output logic [183:0] mem_wb_bus,
  output logic [38:0]  mem_id_bus,
  output logic         mem_excp,
  input  logic         flush
);

  localparam int          EX_MEM_BUS_W = 190;
  localparam logic [2:0]  LD_B         = 3'b001;
  localparam logic [2:0]  LD_H         = 3'b010;
  localparam logic [2:0]  LD_BU        = 3'b101;
  localparam logic [2:0]  LD_HU        = 3'b110;

  logic                    mem_valid_q, mem_valid_d;
  logic                    first_cycle_q, first_cycle_d;
  logic                    held_q, held_d;
  logic [31:0]             rdata_hold_q, rdata_hold_d;
  logic [EX_MEM_BUS_W-1:0] bus_q, bus_d;

  logic        gr_we, res_from_mem, csr_we, csr_re, ertn, syscall;
  logic [2:0]  mem_type;
  logic [1:0]  addr_low2;
  logic [4:0]  dest;
  logic [31:0] pc, inst, result, csr_wmask, csr_wvalue;
  logic [13:0] csr_num;

  logic        leave;
  logic [31:0] load_word, load_data, final_result;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  assign {gr_we, res_from_mem, mem_type, addr_low2, dest, pc, inst, result,
          csr_we, csr_re, csr_num, csr_wmask, csr_wvalue, ertn, syscall} = bus_q;

  assign mem_wb_valid = mem_valid_q & ~flush;
  assign leave        = mem_wb_valid & wb_allowin;
  assign mem_allowin  = ~mem_valid_q | leave;

  // Live SRAM data is only meaningful in the first cycle of occupancy.
  always_comb begin
    load_word = held_q ? rdata_hold_q : data_sram_rdata;
    case (addr_low2)
      2'd0:    load_byte = load_word[7:0];
      2'd1:    load_byte = load_word[15:8];
      2'd2:    load_byte = load_word[23:16];
      default: load_byte = load_word[31:24];
    endcase
    load_half = addr_low2[1] ? load_word[31:16] : load_word[15:0];
    case (mem_type)
      LD_B:    load_data = {{24{load_byte[7]}}, load_byte};
      LD_H:    load_data = {{16{load_half[15]}}, load_half};
      LD_BU:   load_data = {24'd0, load_byte};
      LD_HU:   load_data = {16'd0, load_half};
      default: load_data = load_word;
    endcase
    final_result = res_from_mem ? load_data : result;
  end

  always_comb begin
    mem_valid_d   = mem_valid_q;
    first_cycle_d = 1'b0;
    held_d        = held_q;
    rdata_hold_d  = rdata_hold_q;
    bus_d         = bus_q;
    if (mem_allowin) begin
      mem_valid_d   = ex_mem_valid & ~flush;
      first_cycle_d = ex_mem_valid & ~flush;
    end else if (flush) begin
      mem_valid_d = 1'b0;
    end
    if (ex_mem_valid && mem_allowin) begin
      bus_d = ex_mem_bus;
    end
    // Capture the SRAM word if the load is still resident after its first cycle.
    if (flush || leave) begin
      held_d = 1'b0;
    end else if (mem_valid_q && first_cycle_q) begin
      held_d       = 1'b1;
      rdata_hold_d = data_sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid_q   <= 1'b0;
      first_cycle_q <= 1'b0;
      held_q        <= 1'b0;
      rdata_hold_q  <= 32'd0;
    end else begin
      mem_valid_q   <= mem_valid_d;
      first_cycle_q <= first_cycle_d;
      held_q        <= held_d;
      rdata_hold_q  <= rdata_hold_d;
    end
  end

  always_ff @(posedge clk) begin
    bus_q <= bus_d;
  end

  assign mem_wb_bus = {gr_we, dest, pc, inst, final_result, csr_we, csr_re,
                       csr_num, csr_wmask, csr_wvalue, ertn, syscall};
  assign mem_id_bus = {mem_valid_q & gr_we, dest, final_result,
                       mem_valid_q & (csr_we | csr_re)};
  assign mem_excp   = mem_valid_q & (ertn | syscall);

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_mem_stage : self-checking bench for mem_stage.                      |
// | Revision     : 1.0                                                     |
// +------------------------------------------------------------------------+
module tb_mem_stage;

  typedef struct packed {
    logic        gr_we;
    logic        res_from_mem;
    logic [2:0]  mem_type;
    logic [1:0]  addr;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] result;
    logic        csr_we;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] wmask;
    logic [31:0] wvalue;
    logic        ertn;
    logic        syscall;
  } instr_t;

  logic         clk;
  logic         reset;
  logic         mem_allowin;
  logic         ex_mem_valid;
  logic [189:0] ex_mem_bus;
  logic [31:0]  data_sram_rdata;
  logic         mem_wb_valid;
  logic         wb_allowin;
  logic [183:0] mem_wb_bus;
  logic [38:0]  mem_id_bus;
  logic         mem_excp;
  logic         flush;

  int total = 0;
  int bad   = 0;

  mem_stage dut (
    .clk             (clk),
    .reset           (reset),
    .mem_allowin     (mem_allowin),
    .ex_mem_valid    (ex_mem_valid),
    .ex_mem_bus      (ex_mem_bus),
    .data_sram_rdata (data_sram_rdata),
    .mem_wb_valid    (mem_wb_valid),
    .wb_allowin      (wb_allowin),
    .mem_wb_bus      (mem_wb_bus),
    .mem_id_bus      (mem_id_bus),
    .mem_excp        (mem_excp),
    .flush           (flush)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic instr_t rand_instr();
    instr_t i;
    i.gr_we        = 1'($urandom);
    i.res_from_mem = 1'($urandom);
    i.mem_type     = 3'($urandom);
    i.addr         = 2'($urandom);
    i.dest         = 5'($urandom);
    i.pc           = $urandom;
    i.inst         = $urandom;
    i.result       = $urandom;
    i.csr_we       = ($urandom_range(0, 5) == 0);
    i.csr_re       = ($urandom_range(0, 5) == 0);
    i.csr_num      = 14'($urandom);
    i.wmask        = $urandom;
    i.wvalue       = $urandom;
    i.ertn         = ($urandom_range(0, 9) == 0);
    i.syscall      = ($urandom_range(0, 9) == 0);
    return i;
  endfunction

  function automatic instr_t mk_load(logic [2:0] t, logic [1:0] a);
    instr_t i;
    i = rand_instr();
    i.gr_we = 1'b1; i.res_from_mem = 1'b1; i.mem_type = t; i.addr = a;
    i.csr_we = 1'b0; i.csr_re = 1'b0; i.ertn = 1'b0; i.syscall = 1'b0;
    return i;
  endfunction

  // Architectural load semantics, written as plain shift/mask arithmetic.
  function automatic logic [31:0] ref_final(instr_t i, logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * i.addr)) & 32'hFF;
    h = (w >> (16 * (i.addr / 2))) & 32'hFFFF;
    if (!i.res_from_mem) return i.result;
    case (i.mem_type)
      3'b001:  return (b >= 32'd128)   ? b - 32'd256   : b;
      3'b010:  return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'b101:  return b;
      3'b110:  return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [183:0] ref_wb_bus(instr_t i, logic [31:0] f);
    return {i.gr_we, i.dest, i.pc, i.inst, f, i.csr_we, i.csr_re, i.csr_num,
            i.wmask, i.wvalue, i.ertn, i.syscall};
  endfunction

  task automatic idle_inputs;
    ex_mem_valid = 1'b0; ex_mem_bus = '0; wb_allowin = 1'b1; flush = 1'b0;
    data_sram_rdata = $urandom;
  endtask

  task automatic test_reset;
    instr_t i;
    i = rand_instr();
    i.ertn = 1'b1; i.gr_we = 1'b1; i.csr_we = 1'b1;
    reset = 1'b1; ex_mem_valid = 1'b1; ex_mem_bus = i; wb_allowin = 1'b0; flush = 1'b0;
    tick;
    tick;
    total++; if (mem_wb_valid !== 1'b0) begin bad++; $display("FAIL reset_wbv: got %b want 0", mem_wb_valid); end
    total++; if (mem_allowin !== 1'b1) begin bad++; $display("FAIL reset_allowin: got %b want 1", mem_allowin); end
    total++; if (mem_excp !== 1'b0) begin bad++; $display("FAIL reset_excp: got %b want 0", mem_excp); end
    total++; if ({mem_id_bus[38], mem_id_bus[0]} !== 2'b00) begin
      bad++; $display("FAIL reset_fwd_csr: got %b want 00", {mem_id_bus[38], mem_id_bus[0]});
    end
    reset = 1'b0;
    idle_inputs();
    tick;
  endtask

  task automatic test_align;
    logic [2:0]  t[3] = '{3'b001, 3'b110, 3'b010};
    logic [1:0]  a[3] = '{2'b11, 2'b10, 2'b10};
    logic [31:0] w[3] = '{32'h80FF_0000, 32'h8001_1234, 32'h8001_1234};
    logic [31:0] e[3] = '{32'hFFFF_FF80, 32'h0000_8001, 32'hFFFF_8001};
    for (int k = 0; k < 3; k++) begin
      ex_mem_valid = 1'b1; ex_mem_bus = mk_load(t[k], a[k]); wb_allowin = 1'b1;
      tick;
      ex_mem_valid = 1'b0; data_sram_rdata = w[k];
      #1;
      total++; if (mem_id_bus[32:1] !== e[k]) begin
        bad++; $display("FAIL align_%0d: got %h want %h", k, mem_id_bus[32:1], e[k]);
      end
      tick;
    end
  endtask

  task automatic test_hold;
    ex_mem_valid = 1'b1; ex_mem_bus = mk_load(3'b000, 2'b00); wb_allowin = 1'b0;
    tick;
    ex_mem_valid = 1'b0; data_sram_rdata = 32'hDEAD_BEEF;
    #1;
    total++; if (mem_allowin !== 1'b0) begin bad++; $display("FAIL hold_stall_allowin: got %b want 0", mem_allowin); end
    tick;
    data_sram_rdata = 32'h0;
    tick;
    wb_allowin = 1'b1;
    #1;
    total++; if (mem_wb_valid !== 1'b1) begin bad++; $display("FAIL hold_wbv: got %b want 1", mem_wb_valid); end
    total++; if (mem_id_bus[32:1] !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL hold_data: got %h want deadbeef", mem_id_bus[32:1]);
    end
    tick;
    total++; if (mem_wb_valid !== 1'b0) begin bad++; $display("FAIL hold_leave: got %b want 0", mem_wb_valid); end
  endtask

  task automatic test_flush;
    ex_mem_valid = 1'b1; ex_mem_bus = mk_load(3'b000, 2'b01); wb_allowin = 1'b0;
    tick;
    ex_mem_valid = 1'b0; data_sram_rdata = $urandom;
    tick;
    flush = 1'b1;
    #1;
    total++; if (mem_wb_valid !== 1'b0) begin bad++; $display("FAIL flush_same_cycle: got %b want 0", mem_wb_valid); end
    tick;
    flush = 1'b0;
    #1;
    total++; if (mem_wb_valid !== 1'b0) begin bad++; $display("FAIL flush_wbv: got %b want 0", mem_wb_valid); end
    total++; if (mem_allowin !== 1'b1) begin bad++; $display("FAIL flush_allowin: got %b want 1", mem_allowin); end
    // Flush coincident with an incoming instruction drops it.
    ex_mem_valid = 1'b1; ex_mem_bus = mk_load(3'b000, 2'b00); flush = 1'b1;
    tick;
    ex_mem_valid = 1'b0; flush = 1'b0;
    #1;
    total++; if (mem_wb_valid !== 1'b0) begin bad++; $display("FAIL flush_drop: got %b want 0", mem_wb_valid); end
    wb_allowin = 1'b1;
  endtask

  task automatic test_alu_fwd;
    instr_t i;
    i = rand_instr();
    i.res_from_mem = 1'b0; i.gr_we = 1'b1; i.dest = 5'd5; i.result = 32'h1234_5678;
    i.csr_we = 1'b0; i.csr_re = 1'b0; i.ertn = 1'b0; i.syscall = 1'b0;
    ex_mem_valid = 1'b1; ex_mem_bus = i; wb_allowin = 1'b1;
    tick;
    ex_mem_valid = 1'b0;
    #1;
    total++; if (mem_id_bus !== {1'b1, 5'd5, 32'h1234_5678, 1'b0}) begin
      bad++; $display("FAIL alu_fwd: got %h want %h", mem_id_bus, {1'b1, 5'd5, 32'h1234_5678, 1'b0});
    end
    i.syscall = 1'b1; i.csr_re = 1'b1; i.gr_we = 1'b0;
    ex_mem_valid = 1'b1; ex_mem_bus = i;
    tick;
    ex_mem_valid = 1'b0;
    #1;
    total++; if ({mem_excp, mem_id_bus[38], mem_id_bus[0]} !== 3'b101) begin
      bad++; $display("FAIL excp_csr: got %b want 101", {mem_excp, mem_id_bus[38], mem_id_bus[0]});
    end
    tick;
  endtask

  task automatic test_reset_stall;
    instr_t i;
    i = mk_load(3'b000, 2'b00);
    ex_mem_valid = 1'b1; ex_mem_bus = i; wb_allowin = 1'b0;
    tick;
    ex_mem_valid = 1'b0; data_sram_rdata = 32'hAAAA_5555;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1;
    total++; if (mem_wb_valid !== 1'b0) begin bad++; $display("FAIL rst_stall_wbv: got %b want 0", mem_wb_valid); end
    total++; if (mem_allowin !== 1'b1) begin bad++; $display("FAIL rst_stall_allowin: got %b want 1", mem_allowin); end
    // A fresh load must see live data, not the stale held word.
    ex_mem_valid = 1'b1; ex_mem_bus = i;
    tick;
    ex_mem_valid = 1'b0; data_sram_rdata = 32'h1357_9BDF;
    #1;
    total++; if (mem_id_bus[32:1] !== 32'h1357_9BDF) begin
      bad++; $display("FAIL rst_stall_live: got %h want 13579bdf", mem_id_bus[32:1]);
    end
    wb_allowin = 1'b1;
    tick;
  endtask

  task automatic test_back_to_back;
    instr_t      ins[8];
    logic [31:0] wds[8];
    logic [31:0] exp_f;
    for (int k = 0; k < 8; k++) begin
      ins[k] = mk_load(3'($urandom), 2'($urandom));
      wds[k] = $urandom;
    end
    wb_allowin = 1'b1; flush = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      ex_mem_valid = (k < 8);
      if (k < 8) ex_mem_bus = ins[k];
      if (k > 0) data_sram_rdata = wds[k-1];
      #1;
      total++; if (mem_allowin !== 1'b1) begin bad++; $display("FAIL b2b_allowin_%0d: got %b want 1", k, mem_allowin); end
      if (k > 0) begin
        exp_f = ref_final(ins[k-1], wds[k-1]);
        total++; if (mem_wb_valid !== 1'b1) begin bad++; $display("FAIL b2b_wbv_%0d: got %b want 1", k, mem_wb_valid); end
        total++; if (mem_id_bus[32:1] !== exp_f) begin
          bad++; $display("FAIL b2b_data_%0d: got %h want %h", k, mem_id_bus[32:1], exp_f);
        end
      end
      tick;
    end
    ex_mem_valid = 1'b0;
  endtask

  task automatic test_random;
    logic        m_valid = 1'b0, m_first = 1'b0;
    instr_t      m_i = '0, nxt;
    logic [31:0] m_word = '0, nxt_word, exp_f;
    logic        fl, wb, exv, e_wbv, e_allow;
    idle_inputs();
    tick;
    tick;
    for (int c = 0; c < 600; c++) begin
      fl  = ($urandom_range(0, 9) == 0);
      wb  = ($urandom_range(0, 3) != 0);
      exv = ($urandom_range(0, 2) != 0);
      nxt = rand_instr();
      nxt_word = $urandom;
      flush = fl; wb_allowin = wb; ex_mem_valid = exv; ex_mem_bus = nxt;
      data_sram_rdata = (m_valid && m_first) ? m_word : $urandom;
      #1;
      e_wbv   = m_valid & ~fl;
      e_allow = ~m_valid | (e_wbv & wb);
      exp_f   = ref_final(m_i, m_word);
      total++; if (mem_wb_valid !== e_wbv) begin bad++; $display("FAIL rnd_wbv c%0d: got %b want %b", c, mem_wb_valid, e_wbv); end
      total++; if (mem_allowin !== e_allow) begin bad++; $display("FAIL rnd_allowin c%0d: got %b want %b", c, mem_allowin, e_allow); end
      total++; if (mem_excp !== (m_valid & (m_i.ertn | m_i.syscall))) begin
        bad++; $display("FAIL rnd_excp c%0d: got %b want %b", c, mem_excp, m_valid & (m_i.ertn | m_i.syscall));
      end
      total++; if ({mem_id_bus[38], mem_id_bus[0]} !== {m_valid & m_i.gr_we, m_valid & (m_i.csr_we | m_i.csr_re)}) begin
        bad++; $display("FAIL rnd_fwd_csr c%0d: got %b want %b", c, {mem_id_bus[38], mem_id_bus[0]},
                        {m_valid & m_i.gr_we, m_valid & (m_i.csr_we | m_i.csr_re)});
      end
      if (m_valid) begin
        total++; if (mem_id_bus[37:1] !== {m_i.dest, exp_f}) begin
          bad++; $display("FAIL rnd_id_bus c%0d: got %h want %h", c, mem_id_bus[37:1], {m_i.dest, exp_f});
        end
      end
      if (e_wbv) begin
        total++; if (mem_wb_bus !== ref_wb_bus(m_i, exp_f)) begin
          bad++; $display("FAIL rnd_wb_bus c%0d: got %h want %h", c, mem_wb_bus, ref_wb_bus(m_i, exp_f));
        end
      end
      tick;
      if (e_allow) begin
        m_valid = exv & ~fl;
        m_first = m_valid;
        if (m_valid) begin
          m_i    = nxt;
          m_word = nxt_word;
        end
      end else begin
        if (fl) m_valid = 1'b0;
        m_first = 1'b0;
      end
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_align();
    test_hold();
    test_flush();
    test_alu_fwd();
    test_reset_stall();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports, clock and reset first: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have reset  in  1  synchronous, active-high reset (one clock, synchronous active-high reset -- fixed).
REQ-003 SHALL have mem_allowin  out  1  stage can accept from EX this cycle.
REQ-004 SHALL have ex_mem_valid  in  1  EX offers an instruction.
REQ-005 SHALL have ex_mem_bus  in  190  MSB->LSB: gr_we, res_from_mem, mem_type[2:0], addr_low2[1:0], dest[4:0], pc[31:0], inst[31:0], result[31:0], csr_we, csr_re, csr_num[13:0], csr_wmask[31:0], csr_wvalue[31:0], ertn, syscall.
REQ-006 SHALL have data_sram_rdata  in  32  synchronous SRAM read data, valid exactly one cycle after EX issued the address.
REQ-007 SHALL have mem_wb_valid  out  1 and wb_allowin  in  1: MEM->WB handshake.
REQ-008 SHALL have mem_wb_bus  out  184  MSB->LSB: gr_we, dest, pc, inst, final_result, csr_we, csr_re, csr_num, csr_wmask, csr_wvalue, ertn, syscall.
REQ-009 SHALL have mem_id_bus  out  39  {fwd_valid, dest[4:0], final_result[31:0], csr_hazard}.
REQ-010 SHALL have mem_excp  out  1  valid ertn or syscall resident in MEM (EX uses it to kill stores).
REQ-011 SHALL have flush  in  1  ertn/exception flush from WB.

Function
REQ-012 mem_ready_go SHALL be 1; mem_wb_valid = mem_valid & ~flush.
REQ-013 mem_allowin SHALL be ~mem_valid | (mem_wb_valid & wb_allowin).
REQ-014 When mem_allowin: mem_valid <= ex_mem_valid & ~flush; bus register loads ex_mem_bus only when ex_mem_valid & mem_allowin.
REQ-015 flush SHALL clear mem_valid next cycle regardless of wb_allowin; flushed instruction never appears on mem_wb_valid.
REQ-016 first_cycle flag SHALL be 1 in the first cycle of each new instruction's occupancy, 0 afterwards.
REQ-017 Read-data hold: if first_cycle & ~(mem_wb_valid & wb_allowin), rdata_hold <= data_sram_rdata, held <= 1; held clears when the instruction leaves or flush.
REQ-018 Load source SHALL be held ? rdata_hold : data_sram_rdata; never live rdata after first cycle.
REQ-019 mem_type: 000 ld.w, 001 ld.b, 010 ld.h, 101 ld.bu, 110 ld.hu; other codes SHALL yield word result.
REQ-020 Byte select = addr_low2 (byte 0 = bits 7:0); halfword select = addr_low2[1] (0 -> bits 15:0, 1 -> 31:16).
REQ-021 ld.b/ld.h SHALL sign-extend to 32 bits; ld.bu/ld.hu SHALL zero-extend.
REQ-022 final_result SHALL be aligned load data when res_from_mem, else result field unchanged.
REQ-023 fwd_valid SHALL be mem_valid & gr_we; csr_hazard = mem_valid & (csr_we | csr_re).
REQ-024 mem_excp SHALL be mem_valid & (ertn | syscall).
REQ-025 Simultaneous flush and ex_mem_valid: incoming instruction SHALL be dropped.
REQ-026 Back-to-back loads with wb_allowin=1 SHALL sustain one instruction per cycle, zero bubbles.

Reset
REQ-027 reset SHALL clear mem_valid, held, first_cycle, rdata_hold; mem_wb_valid, mem_excp, fwd_valid, csr_hazard read 0 the cycle after reset asserts.
REQ-028 Reset asserted mid-stall SHALL discard resident instruction and held data; bus register contents SHALL be don't-care.

Verification
REQ-029 ld.b, addr_low2=2'b11, rdata=0x80FF_0000 -> final_result 0xFFFF_FF80.
REQ-030 ld.hu, addr_low2=2'b10, rdata=0x8001_1234 -> final_result 0x0000_8001; ld.h same -> 0xFFFF_8001.
REQ-031 ld.w rdata=0xDEAD_BEEF, wb_allowin=0 for 3 cycles, rdata changes to 0x0 after cycle 1 -> on release final_result 0xDEAD_BEEF.
REQ-032 flush asserted while load resident and wb_allowin=0 -> mem_wb_valid=0 next cycle, mem_allowin=1.
REQ-033 ALU op result=0x1234_5678, gr_we=1, dest=5 -> mem_id_bus = {1, 5'd5, 0x1234_5678, 0}.
REQ-034 reset=1 during held stall -> next cycle mem_valid=0, mem_wb_valid=0, mem_allowin=1.
